// File: rtl/sub_pipe.sv
// -----------------------------------------------------------------------------
// sub_pipe
//
// Multi-lane elastic valid/ready pipeline. Each accepted beat carries NUM_CH
// lanes of TYPE_t; every lane is either inverted or passed through at the
// moment of acceptance (selected by the matching mode_inv bit), then travels
// through DEPTH register stages. Output transfers are counted by a
// saturating counter.
//
// Parameters
//    TYPE_t  lane data type (packed), W = $bits(TYPE_t)
//    NUM_CH  number of lanes (>= 1)
//    DEPTH   number of register stages (>= 1)
//    CNT_W   width of xfer_count
//
// Ports
//    clk         clock, all state updates on the rising edge
//    reset_l     asynchronous active-low reset
//    flush       synchronous clear of every stage valid bit
//    in_valid    upstream beat valid
//    in_ready    beat accepted this cycle when in_valid is also high
//    in_data     lane array, index 0 = lane 0
//    mode_inv    per-lane select, 1 = invert, 0 = pass (sampled with beat)
//    out_valid   downstream beat valid (masked low while flush is high)
//    out_ready   downstream accepts
//    out_data    transformed lane array of the last stage
//    xfer_count  saturating count of output transfers
//    busy        some stage holds a valid beat
// -----------------------------------------------------------------------------
module sub_pipe #(
   parameter type TYPE_t = logic [7:0],
   parameter int  NUM_CH = 2,
   parameter int  DEPTH  = 2,
   parameter int  CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  TYPE_t             in_data [NUM_CH],
   input  logic [NUM_CH-1:0] mode_inv,
   output logic              out_valid,
   input  logic              out_ready,
   output TYPE_t             out_data [NUM_CH],
   output logic [CNT_W-1:0]  xfer_count,
   output logic              busy
);

   localparam int W = $bits(TYPE_t);

   logic [DEPTH-1:0] r_v;
   logic [W-1:0]     r_data [DEPTH][NUM_CH];
   logic [CNT_W-1:0] r_cnt;

   logic [DEPTH:0]   w_rdy;
   logic [W-1:0]     w_in_bits [NUM_CH];
   logic [W-1:0]     w_in_xf   [NUM_CH];
   logic             w_out_xfer;

   // Per-lane transform, applied once at acceptance so later mode_inv
   // changes never touch beats already stored.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
         assign w_in_bits[gi] = in_data[gi];
         assign w_in_xf[gi]   = mode_inv[gi] ? ~w_in_bits[gi] : w_in_bits[gi];
         assign out_data[gi]  = r_data[DEPTH-1][gi];
      end
   endgenerate

   // Ready chain rdy[i] = !v[i] || rdy[i+1], written in closed form: stage i
   // can load when the consumer is ready or any stage at or after i is empty.
   // This keeps every rdy bit a function of r_v and out_ready only.
   assign w_rdy[DEPTH] = out_ready;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_rdy
         assign w_rdy[gi] = out_ready || !(&r_v[DEPTH-1:gi]);
      end
   endgenerate

   assign in_ready   = w_rdy[0] && !flush;
   assign out_valid  = r_v[DEPTH-1] && !flush;
   assign w_out_xfer = out_valid && out_ready;
   assign busy       = |r_v;
   assign xfer_count = r_cnt;

   // Stage registers. Data only moves when the upstream slot is valid, so an
   // empty slot keeps its old contents instead of toggling on idle input.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_v <= '0;
         for (int s = 0; s < DEPTH; s++) begin
            for (int k = 0; k < NUM_CH; k++) begin
               r_data[s][k] <= '0;
            end
         end
      end else if (flush) begin
         r_v <= '0;
      end else begin
         if (w_rdy[0]) begin
            r_v[0] <= in_valid;
            if (in_valid) begin
               r_data[0] <= w_in_xf;
            end
         end
         for (int s = 1; s < DEPTH; s++) begin
            if (w_rdy[s]) begin
               r_v[s] <= r_v[s-1];
               if (r_v[s-1]) begin
                  r_data[s] <= r_data[s-1];
               end
            end
         end
      end
   end

   // Saturating transfer counter; flush never touches it.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_cnt <= '0;
      end else if (w_out_xfer && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_sub_pipe
//
// Bench for sub_pipe. A negedge monitor keeps a queue of expected beats
// (pushed on input transfer, popped and compared on output transfer) and a
// model of xfer_count. Scenario tasks add their own timing/handshake checks.
// A second instance with CNT_W = 4 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_sub_pipe;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data [2];
   logic [1:0]  mode_inv;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data [2];
   logic [15:0] xfer_count;
   logic        busy;

   logic        flush4;
   logic        in_valid4;
   logic        in_ready4;
   logic [7:0]  in_data4 [2];
   logic [1:0]  mode4;
   logic        out_valid4;
   logic        out_ready4;
   logic [7:0]  out_data4 [2];
   logic [3:0]  xfer_count4;
   logic        busy4;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] sb [$];
   int          exp_cnt = 0;
   int          t4 = 0;

   always #5 clk = ~clk;

   sub_pipe #(.TYPE_t(logic [7:0]), .NUM_CH(2), .DEPTH(2), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_l    (reset_l),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .mode_inv   (mode_inv),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .xfer_count (xfer_count),
      .busy       (busy)
   );

   sub_pipe #(.TYPE_t(logic [7:0]), .NUM_CH(2), .DEPTH(2), .CNT_W(4)) dut4 (
      .clk        (clk),
      .reset_l    (reset_l),
      .flush      (flush4),
      .in_valid   (in_valid4),
      .in_ready   (in_ready4),
      .in_data    (in_data4),
      .mode_inv   (mode4),
      .out_valid  (out_valid4),
      .out_ready  (out_ready4),
      .out_data   (out_data4),
      .xfer_count (xfer_count4),
      .busy       (busy4)
   );

   // Scoreboard monitor: handshakes sampled at negedge apply to the next
   // rising edge.
   always @(negedge clk) begin
      logic [15:0] e;
      logic [7:0]  e0, e1;
      if (!reset_l) begin
         sb.delete();
         exp_cnt = 0;
      end else if (flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
               $display("FAIL sb_underflow: got beat %h_%h, expected no beat",
                        out_data[1], out_data[0]);
            end else begin
               e = sb.pop_front();
               if ({out_data[1], out_data[0]} !== e)
                  $display("FAIL sb_data: got %h_%h, expected %h_%h",
                           out_data[1], out_data[0], e[15:8], e[7:0]);
               else
                  n_pass++;
            end
            exp_cnt++;
         end
         if (in_valid && in_ready) begin
            e0 = mode_inv[0] ? ~in_data[0] : in_data[0];
            e1 = mode_inv[1] ? ~in_data[1] : in_data[1];
            sb.push_back({e1, e0});
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_l)
         t4 = 0;
      else if (out_valid4 && out_ready4 && !flush4)
         t4++;
   end

   task automatic test_reset();
      #2;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
      n_chk++; if (xfer_count !== 16'd0) $display("FAIL rst_count: got %0d expected 0", xfer_count); else n_pass++;
      n_chk++;
      if (out_data[0] !== 8'h00 || out_data[1] !== 8'h00)
         $display("FAIL rst_out_data: got %h_%h expected 00_00", out_data[1], out_data[0]);
      else n_pass++;
      @(posedge clk); #1;
      reset_l = 1'b1;
      @(posedge clk); #1;
   endtask

   // Beat offered in cycle c appears on out_valid in cycle c+2.
   task automatic test_single();
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_data[0]  = 8'h0F;
      in_data[1]  = 8'hA5;
      mode_inv    = 2'b01;
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b expected 1", in_ready); else n_pass++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL single_early: got out_valid %b expected 0", out_valid); else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL single_latency: got out_valid %b expected 1", out_valid); else n_pass++;
      n_chk++;
      if (out_data[0] !== 8'hF0 || out_data[1] !== 8'hA5)
         $display("FAIL single_data: got %h_%h expected A5_F0", out_data[1], out_data[0]);
      else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (xfer_count !== 16'd1) $display("FAIL single_count: got %0d expected 1", xfer_count); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL single_drain: got out_valid %b expected 0", out_valid); else n_pass++;
   endtask

   task automatic test_backpressure();
      int  nxt;
      bit  acc;
      out_ready  = 1'b0;
      in_data[1] = 8'h00;
      mode_inv   = 2'b00;
      nxt = 1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_valid   = 1'b1;
         in_data[0] = 8'(nxt);
         @(negedge clk);
         acc = in_ready;
         if (cyc >= 2) begin
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: cyc %0d got %b expected 0", cyc, in_ready); else n_pass++;
            n_chk++; if (out_data[0] !== 8'h01 || out_valid !== 1'b1)
               $display("FAIL bp_stable: cyc %0d got v=%b d=%h expected v=1 d=01", cyc, out_valid, out_data[0]);
            else n_pass++;
         end
         @(posedge clk); #1;
         if (acc) nxt++;
      end
      n_chk++; if (nxt !== 3) $display("FAIL bp_accepted: got %0d beats expected 2", nxt - 1); else n_pass++;
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         in_valid   = (nxt <= 4);
         in_data[0] = 8'(nxt);
         @(negedge clk);
         acc = in_valid && in_ready;
         n_chk++;
         if (out_valid !== 1'b1 || out_data[0] !== 8'(r + 1))
            $display("FAIL bp_order: slot %0d got v=%b d=%h expected v=1 d=%h", r, out_valid, out_data[0], 8'(r + 1));
         else n_pass++;
         @(posedge clk); #1;
         if (acc) nxt++;
      end
      in_valid = 1'b0;
      n_chk++; if (nxt !== 5) $display("FAIL bp_total: got %0d beats expected 4", nxt - 1); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL bp_empty: got busy %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n_ov  = 0;
      int first = -1;
      int last  = -1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         in_valid = (cyc < 10);
         in_data[0] = 8'($urandom_range(0, 255));
         in_data[1] = 8'($urandom_range(0, 255));
         mode_inv   = 2'($urandom_range(0, 3));
         @(negedge clk);
         if (cyc < 10) begin
            n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: cyc %0d got %b expected 1", cyc, in_ready); else n_pass++;
         end
         if (out_valid) begin
            n_ov++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++; if (n_ov !== 10) $display("FAIL b2b_count: got %0d valid cycles expected 10", n_ov); else n_pass++;
      n_chk++; if (first !== 2 || last !== 11) $display("FAIL b2b_window: got %0d..%0d expected 2..11", first, last); else n_pass++;
      n_chk++; if (xfer_count !== 16'(exp_cnt)) $display("FAIL b2b_xfer: got %0d expected %0d", xfer_count, exp_cnt); else n_pass++;
      n_chk++; if (xfer_count !== 16'd15) $display("FAIL b2b_xfer_abs: got %0d expected 15", xfer_count); else n_pass++;
   endtask

   task automatic test_flush();
      int cnt_before;
      out_ready  = 1'b0;
      mode_inv   = 2'b00;
      in_data[1] = 8'h00;
      in_valid   = 1'b1;
      in_data[0] = 8'h11;
      @(posedge clk); #1;
      in_data[0] = 8'h22;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b0) $display("FAIL fl_full: got in_ready %b expected 0", in_ready); else n_pass++;
      cnt_before = exp_cnt;
      @(posedge clk); #1;
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data[0] = 8'h33;
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL fl_out_mask: got %b expected 0", out_valid); else n_pass++;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL fl_in_mask: got %b expected 0", in_ready); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL fl_busy_during: got %b expected 1", busy); else n_pass++;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      n_chk++; if (busy !== 1'b0) $display("FAIL fl_busy_after: got %b expected 0", busy); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL fl_valid_after: got %b expected 0", out_valid); else n_pass++;
      n_chk++; if (xfer_count !== 16'(cnt_before)) $display("FAIL fl_count: got %0d expected %0d", xfer_count, cnt_before); else n_pass++;
      // Pipe must still work after the flush.
      in_valid   = 1'b1;
      in_data[0] = 8'h5A;
      in_data[1] = 8'hC3;
      mode_inv   = 2'b10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
      end
      n_chk++; if (sb.size() !== 0) $display("FAIL fl_drain: got %0d beats pending expected 0", sb.size()); else n_pass++;
      n_chk++; if (xfer_count !== 16'(cnt_before + 1)) $display("FAIL fl_count_post: got %0d expected %0d", xfer_count, cnt_before + 1); else n_pass++;
   endtask

   task automatic test_saturate();
      int ev;
      out_ready4 = 1'b1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         in_valid4   = (cyc < 20);
         in_data4[0] = 8'(cyc);
         @(posedge clk); #1;
         ev = (t4 > 15) ? 15 : t4;
         n_chk++;
         if (xfer_count4 !== 4'(ev))
            $display("FAIL sat_count: after %0d transfers got %0d expected %0d", t4, xfer_count4, ev);
         else n_pass++;
      end
      in_valid4 = 1'b0;
      n_chk++; if (t4 !== 20) $display("FAIL sat_total: got %0d transfers expected 20", t4); else n_pass++;
      n_chk++; if (xfer_count4 !== 4'hF) $display("FAIL sat_final: got %h expected f", xfer_count4); else n_pass++;
   endtask

   task automatic test_reset_midstream();
      out_ready  = 1'b0;
      mode_inv   = 2'b11;
      in_data[0] = 8'h55;
      in_data[1] = 8'h66;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_chk++; if (busy !== 1'b1 || out_valid !== 1'b1) $display("FAIL mr_loaded: got busy %b valid %b expected 1 1", busy, out_valid); else n_pass++;
      #2;
      reset_l = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL mr_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL mr_in_ready: got %b expected 1", in_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL mr_busy: got %b expected 0", busy); else n_pass++;
      n_chk++; if (xfer_count !== 16'd0) $display("FAIL mr_count: got %0d expected 0", xfer_count); else n_pass++;
      n_chk++; if (xfer_count4 !== 4'd0) $display("FAIL mr_count4: got %0d expected 0", xfer_count4); else n_pass++;
      n_chk++;
      if (out_data[0] !== 8'h00 || out_data[1] !== 8'h00)
         $display("FAIL mr_out_data: got %h_%h expected 00_00", out_data[1], out_data[0]);
      else n_pass++;
      @(negedge clk);
      @(posedge clk); #1;
      reset_l = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (busy !== 1'b0) $display("FAIL mr_after: got busy %b expected 0", busy); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_l     = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_data[0]  = 8'h00;
      in_data[1]  = 8'h00;
      mode_inv    = 2'b00;
      flush4      = 1'b0;
      in_valid4   = 1'b0;
      out_ready4  = 1'b0;
      in_data4[0] = 8'h00;
      in_data4[1] = 8'h00;
      mode4       = 2'b00;

      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_saturate();
      test_reset_midstream();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sub_pipe.md
Name: sub_pipe

Overview:
- Parametrised, multi-channel successor of the single-lane combinational inverter sub-block.
- Carries NUM_CH lanes of a user-supplied data type through a DEPTH-stage elastic valid/ready pipeline.
- Applies a per-lane invert-or-pass transform at acceptance and counts completed output transfers.
- Used as a registered datapath leaf under generic top-level wrappers, and as a parameter-type exercise for the tool flow.

Parameters:
- TYPE_t, logic [7:0], lane data type (type parameter); W = $bits(TYPE_t).
- NUM_CH, 2, number of lanes; must be >= 1.
- DEPTH, 2, pipeline stages; must be >= 1.
- CNT_W, 16, width of xfer_count.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_l  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block accepts beat this cycle.
- in_data  input  NUM_CH x TYPE_t  unpacked lane array; index 0 = lane 0.
- mode_inv  input  NUM_CH  per-lane select: 1 = invert, 0 = pass; sampled with the beat.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  NUM_CH x TYPE_t  transformed lane array.
- xfer_count  output  CNT_W  saturating count of output transfers.
- busy  output  1  any stage holds a valid beat.

Behaviour:
- Reset (reset_l low, asynchronous, any time):
  - All stage valid bits = 0, all stage data = 0, xfer_count = 0.
  - Hence out_valid = 0, out_data = 0, busy = 0, in_ready = 1 (with flush low).
  - A beat in flight when reset asserts is discarded.
- Transform: at input acceptance, lane k is stored as ~in_data[k] if mode_inv[k] = 1, else in_data[k], bitwise over W bits. There is no other arithmetic; later mode_inv changes do not affect stored beats.
- Stages 0..DEPTH-1 each hold {v, data}; out_valid = v[DEPTH-1]; out_data = data[DEPTH-1].
- Ready chain (combinational, no bubbles required):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !v[i] || rdy[i+1].
  - in_ready = rdy[0] && !flush.
- Per-edge update (flush low):
  - Stage i loads from stage i-1 (or the input for i = 0) when rdy[i] = 1; the new v = upstream valid.
  - Otherwise stage i holds.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready && !flush.
- Latency: DEPTH cycles, accept edge to out_valid, with an empty pipe and out_ready = 1. Throughput is one beat per cycle.
- Back-pressure:
  - With out_ready = 0, the pipe fills to DEPTH beats, then in_ready = 0.
  - No beat is dropped or duplicated; order is preserved.
  - out_data is stable while out_valid && !out_ready.
- Flush (synchronous):
  - While flush = 1: in_ready = 0 and out_valid = 0 (masked), so no transfers occur.
  - On the edge, all v bits clear; data is don't-care.
  - xfer_count is not changed by flush.
  - flush with reset_l low: reset dominates.
- xfer_count:
  - Increments by 1 on each output transfer.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - Cleared only by reset.
- busy = OR of all v bits (unmasked by flush).
- Simultaneous input and output transfer on a full pipe: allowed; occupancy is unchanged.

Test Plan:
- Reset with TYPE_t = logic [7:0], NUM_CH = 2, DEPTH = 2, CNT_W = 16 -> out_valid = 0, in_ready = 1, busy = 0, xfer_count = 0, out_data = {0,0}. Assert reset_l low mid-stream -> all of these values immediately, without waiting for a clock edge.
- One beat, in_data = {lane0 8'h0F, lane1 8'hA5}, mode_inv = 2'b01, out_ready = 1 -> out_valid rises 2 cycles after accept, out_data = {8'hF0, 8'hA5}, xfer_count = 1.
- out_ready = 0, offer beats 1,2,3,4 (lane0 = 8'h01..8'h04, pass) -> 2 beats accepted, then in_ready = 0 with out_data stable at 8'h01. Release out_ready -> outputs 01,02,03,04 in order, no gaps after release.
- 10 back-to-back beats, out_ready = 1 -> 10 consecutive out_valid cycles, xfer_count = 10.
- Pipe holding 2 beats, flush = 1 for one cycle -> out_valid = 0 and in_ready = 0 during flush, busy = 0 after the edge, xfer_count unchanged.
- CNT_W = 4, 20 output transfers -> xfer_count = 4'hF from the 15th transfer onward.
